cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer_pkg.sv | 29 ++
 rtl/cpu_sequencer_wait_timer.sv | 36 +++
 rtl/cpu_sequencer.sv | 166 ++++++++++++++++
 tb/tb_cpu_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_sequencer_pkg.sv
// Shared types for the multi-cycle CPU sequencer.
// Holds the sequencer state encoding and small state-class helpers.
package cpu_sequencer_pkg;

    localparam int unsigned INSTR_W = 32;

    typedef enum logic [2:0] {
        FETCH,
        FETCH_WAIT,
        EXEC,
        MEM,
        MEM_WAIT,
        WB,
        HALT,
        FAULT
    } seq_state_t;

    // States that drive a bus request.
    function automatic logic is_bus_req(input seq_state_t s);
        return (s == FETCH) || (s == MEM);
    endfunction

    // States in which the bus wait limit applies.
    function automatic logic is_timed(input seq_state_t s);
        return (s == FETCH) || (s == FETCH_WAIT) ||
               (s == MEM)   || (s == MEM_WAIT);
    endfunction

endpackage

// File: rtl/cpu_sequencer_wait_timer.sv
// Bus wait limiter: counts cycles spent in one waiting state.
// Ports: clk, rst_n (sync, active low), i_run (count enable),
//        i_clear (restart at 0), o_expired (limit reached this cycle).
module wait_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_run,
    input  logic i_clear,
    output logic o_expired
);

    localparam int unsigned CW =
        (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    // Count value seen in the last permitted waiting cycle.
    localparam logic [CW-1:0] LAST =
        CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear || !i_run) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // A zero limit disables the timer entirely.
    assign o_expired = (TIMEOUT != 0) && i_run && (r_cnt == LAST);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/exec/mem/writeback sequencer for a simple CPU.
// Ports: clk/rst_n; bus_req_* request channel (valid/ready);
//        bus_rsp_* response; pc/instr/exec_valid to the datapath;
//        dp_mem_* load/store request; mem_rdata/wb_en/pc_next;
//        halt_req/halted/fault status; instret retire counter.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int unsigned      XLEN    = 32,
    parameter logic [XLEN-1:0]  PC_INIT = 'h8000_0000,
    parameter int unsigned      TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                bus_req_valid,
    input  logic                bus_req_ready,
    output logic [XLEN-1:0]     bus_req_addr,
    output logic                bus_req_we,
    output logic [XLEN-1:0]     bus_req_wdata,
    output logic [XLEN/8-1:0]   bus_req_wstrb,
    input  logic                bus_rsp_valid,
    input  logic [XLEN-1:0]     bus_rsp_rdata,
    output logic [XLEN-1:0]     pc,
    output logic [INSTR_W-1:0]  instr,
    output logic                exec_valid,
    input  logic                dp_mem_req,
    input  logic                dp_mem_we,
    input  logic [XLEN-1:0]     dp_mem_addr,
    input  logic [XLEN-1:0]     dp_mem_wdata,
    input  logic [XLEN/8-1:0]   dp_mem_wstrb,
    output logic [XLEN-1:0]     mem_rdata,
    output logic                wb_en,
    input  logic [XLEN-1:0]     pc_next,
    input  logic                halt_req,
    output logic                halted,
    output logic                fault,
    output logic [63:0]         instret
);

    localparam int unsigned SW = XLEN / 8;

    seq_state_t          r_state;
    seq_state_t          w_state_nxt;
    logic [XLEN-1:0]     r_pc;
    logic [INSTR_W-1:0]  r_instr;
    logic [XLEN-1:0]     r_mem_rdata;
    logic [63:0]         r_instret;
    logic                r_dp_we;
    logic [XLEN-1:0]     r_dp_addr;
    logic [XLEN-1:0]     r_dp_wdata;
    logic [SW-1:0]       r_dp_wstrb;

    logic                w_timeout;
    logic                w_run;
    logic                w_clear;
    logic                w_misalign;
    logic                w_in_mem;

    assign w_misalign = |pc_next[1:0];
    assign w_run      = is_timed(r_state);
    assign w_clear    = (w_state_nxt != r_state);
    assign w_in_mem   = (r_state == MEM);

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_run     (w_run),
        .i_clear   (w_clear),
        .o_expired (w_timeout)
    );

    // Next state. An expired wait wins over a same-cycle handshake.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            FETCH: begin
                if (w_timeout)          w_state_nxt = FAULT;
                else if (bus_req_ready) w_state_nxt = FETCH_WAIT;
            end
            FETCH_WAIT: begin
                if (w_timeout)          w_state_nxt = FAULT;
                else if (bus_rsp_valid) w_state_nxt = EXEC;
            end
            EXEC: begin
                w_state_nxt = dp_mem_req ? MEM : WB;
            end
            MEM: begin
                if (w_timeout)          w_state_nxt = FAULT;
                else if (bus_req_ready) w_state_nxt = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (w_timeout)          w_state_nxt = FAULT;
                else if (bus_rsp_valid) w_state_nxt = WB;
            end
            WB: begin
                if (w_misalign)         w_state_nxt = FAULT;
                else if (halt_req)      w_state_nxt = HALT;
                else                    w_state_nxt = FETCH;
            end
            HALT:  w_state_nxt = HALT;
            FAULT: w_state_nxt = FAULT;
            default: w_state_nxt = FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= FETCH;
            r_pc        <= PC_INIT;
            r_instr     <= '0;
            r_mem_rdata <= '0;
            r_instret   <= '0;
            r_dp_we     <= 1'b0;
            r_dp_addr   <= '0;
            r_dp_wdata  <= '0;
            r_dp_wstrb  <= '0;
        end else begin
            r_state <= w_state_nxt;
            unique case (r_state)
                FETCH_WAIT: begin
                    if (bus_rsp_valid && !w_timeout)
                        r_instr <= bus_rsp_rdata[INSTR_W-1:0];
                end
                EXEC: begin
                    r_dp_we    <= dp_mem_we;
                    r_dp_addr  <= dp_mem_addr;
                    r_dp_wdata <= dp_mem_wdata;
                    r_dp_wstrb <= dp_mem_wstrb;
                end
                MEM_WAIT: begin
                    // Store responses leave the last load data intact.
                    if (bus_rsp_valid && !w_timeout && !r_dp_we)
                        r_mem_rdata <= bus_rsp_rdata;
                end
                WB: begin
                    // A misaligned target retires nothing.
                    if (!w_misalign) begin
                        r_pc      <= pc_next;
                        r_instret <= r_instret + 64'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes are forced low for as long as reset is held.
    assign bus_req_valid = rst_n & is_bus_req(r_state);
    assign exec_valid    = rst_n & (r_state == EXEC);
    assign wb_en         = rst_n & (r_state == WB);
    assign halted        = rst_n & (r_state == HALT);
    assign fault         = rst_n & (r_state == FAULT);

    assign bus_req_addr  = w_in_mem ? r_dp_addr : r_pc;
    assign bus_req_we    = w_in_mem & r_dp_we;
    assign bus_req_wdata = w_in_mem ? r_dp_wdata : '0;
    assign bus_req_wstrb = w_in_mem ? r_dp_wstrb : '0;

    assign pc        = r_pc;
    assign instr     = r_instr;
    assign mem_rdata = r_mem_rdata;
    assign instret   = r_instret;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with a bus responder model
// and a writeback scoreboard of expected instr/mem_rdata pairs.
module tb_cpu_sequencer;

    localparam logic [31:0] PC0 = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [31:0] bus_req_addr;
    logic        bus_req_we;
    logic [31:0] bus_req_wdata;
    logic [3:0]  bus_req_wstrb;
    logic        bus_rsp_valid;
    logic [31:0] bus_rsp_rdata;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exec_valid;
    logic        dp_mem_req;
    logic        dp_mem_we;
    logic [31:0] dp_mem_addr;
    logic [31:0] dp_mem_wdata;
    logic [3:0]  dp_mem_wstrb;
    logic [31:0] mem_rdata;
    logic        wb_en;
    logic [31:0] pc_next;
    logic        halt_req;
    logic        halted;
    logic        fault;
    logic [63:0] instret;

    cpu_sequencer #(
        .XLEN    (32),
        .PC_INIT (PC0),
        .TIMEOUT (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus_req_valid (bus_req_valid),
        .bus_req_ready (bus_req_ready),
        .bus_req_addr  (bus_req_addr),
        .bus_req_we    (bus_req_we),
        .bus_req_wdata (bus_req_wdata),
        .bus_req_wstrb (bus_req_wstrb),
        .bus_rsp_valid (bus_rsp_valid),
        .bus_rsp_rdata (bus_rsp_rdata),
        .pc            (pc),
        .instr         (instr),
        .exec_valid    (exec_valid),
        .dp_mem_req    (dp_mem_req),
        .dp_mem_we     (dp_mem_we),
        .dp_mem_addr   (dp_mem_addr),
        .dp_mem_wdata  (dp_mem_wdata),
        .dp_mem_wstrb  (dp_mem_wstrb),
        .mem_rdata     (mem_rdata),
        .wb_en         (wb_en),
        .pc_next       (pc_next),
        .halt_req      (halt_req),
        .halted        (halted),
        .fault         (fault),
        .instret       (instret)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] mrd;
    } sb_t;

    sb_t         sb_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] mem [logic [31:0]];
    int          ready_delay = 0;
    bit          rsp_on = 1'b1;
    bit          pc_fix_en = 1'b0;
    logic [31:0] pc_fix = '0;

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
        cyc++;
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        cyc = 1;
    endtask

    task automatic wait_exec(input int budget);
        for (int i = 0; i < budget && exec_valid !== 1'b1; i++) step();
        check("exec_seen", exec_valid, 1);
    endtask

    task automatic wait_wb(input int budget);
        for (int i = 0; i < budget && wb_en !== 1'b1; i++) step();
        check("wb_seen", wb_en, 1);
    endtask

    task automatic push(input logic [31:0] i, input logic [31:0] m);
        sb_t e;
        e.instr = i;
        e.mrd   = m;
        sb_q.push_back(e);
    endtask

    // Bus slave: ready after ready_delay stalled cycles,
    // response one cycle after each handshake, shares rst_n.
    bit          hs = 1'b0;
    bit          stall_seen = 1'b0;
    logic [31:0] hs_addr, hs_wdata;
    logic        hs_we;
    logic [31:0] st_addr, st_wdata;
    logic [3:0]  st_wstrb;
    int          wait_cnt = 0;

    initial begin : responder
        bus_req_ready = 1'b1;
        bus_rsp_valid = 1'b0;
        bus_rsp_rdata = '0;
        pc_next = PC0 + 32'd4;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && bus_req_valid) begin
                if (stall_seen) begin
                    check("hold_addr", bus_req_addr, st_addr);
                    check("hold_wdata", bus_req_wdata, st_wdata);
                    check("hold_wstrb", bus_req_wstrb, st_wstrb);
                end else begin
                    st_addr  = bus_req_addr;
                    st_wdata = bus_req_wdata;
                    st_wstrb = bus_req_wstrb;
                end
                stall_seen = !bus_req_ready;
                if (bus_req_ready) begin
                    hs       = 1'b1;
                    hs_addr  = bus_req_addr;
                    hs_we    = bus_req_we;
                    hs_wdata = bus_req_wdata;
                end
            end
            @(posedge clk);
            #2;
            bus_rsp_valid = 1'b0;
            if (!rst_n) begin
                hs = 1'b0;
                stall_seen = 1'b0;
                wait_cnt = 0;
                bus_req_ready = (ready_delay == 0);
            end else if (hs) begin
                hs = 1'b0;
                wait_cnt = 0;
                bus_req_ready = (ready_delay == 0);
                bus_rsp_valid = rsp_on;
                if (hs_we) begin
                    mem[hs_addr] = hs_wdata;
                    bus_rsp_rdata = '0;
                end else begin
                    bus_rsp_rdata = mem.exists(hs_addr) ? mem[hs_addr] : '0;
                end
            end else if (bus_req_valid && !bus_req_ready) begin
                if (wait_cnt >= ready_delay) bus_req_ready = 1'b1;
                else wait_cnt++;
            end
            pc_next = pc_fix_en ? pc_fix : pc + 32'd4;
        end
    end

    initial begin : wb_monitor
        sb_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n === 1'b1 && wb_en === 1'b1) begin
                check("sb_nonempty", (sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("sb_instr", instr, e.instr);
                    check("sb_mem_rdata", mem_rdata, e.mrd);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : directed
        int seen;
        halt_req     = 1'b0;
        dp_mem_req   = 1'b0;
        dp_mem_we    = 1'b0;
        dp_mem_addr  = '0;
        dp_mem_wdata = '0;
        dp_mem_wstrb = '0;
        mem[PC0]              = 32'h0000_0013;
        mem[PC0 + 32'd4]      = 32'h0000_2083;
        mem[32'h0000_1000]    = 32'hDEAD_BEEF;

        // Reset state with rst_n held low.
        repeat (3) step();
        check("rst_pc", pc, PC0);
        check("rst_instret", instret, 0);
        check("rst_instr", instr, 0);
        check("rst_mem_rdata", mem_rdata, 0);
        check("rst_req_valid", bus_req_valid, 0);
        check("rst_exec", exec_valid, 0);
        check("rst_wb", wb_en, 0);
        check("rst_halted", halted, 0);
        check("rst_fault", fault, 0);

        // Zero-wait ALU instruction.
        push(32'h0000_0013, 32'h0);
        release_rst();
        check("fetch_valid", bus_req_valid, 1);
        check("fetch_addr", bus_req_addr, PC0);
        check("fetch_we", bus_req_we, 0);
        check("fetch_wstrb", bus_req_wstrb, 0);
        wait_exec(10);
        check("exec_cycle", cyc, 3);
        step();
        check("wb_cycle_4", wb_en, 1);
        check("exec_one_cycle", exec_valid, 0);
        dp_mem_req   = 1'b1;
        dp_mem_we    = 1'b0;
        dp_mem_addr  = 32'h0000_1000;
        dp_mem_wdata = 32'h1234_5678;
        dp_mem_wstrb = 4'hF;
        ready_delay  = 3;
        push(32'h0000_2083, 32'hDEAD_BEEF);
        step();
        check("i1_pc", pc, PC0 + 32'd4);
        check("i1_instret", instret, 1);
        check("i1_wb_one_cycle", wb_en, 0);

        // Load with a 3-cycle ready stall, halt at its writeback.
        wait_exec(20);
        check("i2_exec_cycle", cyc, 7);
        step();
        check("mem_valid", bus_req_valid, 1);
        check("mem_addr", bus_req_addr, 32'h0000_1000);
        check("mem_wdata", bus_req_wdata, 32'h1234_5678);
        check("mem_wstrb", bus_req_wstrb, 4'hF);
        check("mem_we", bus_req_we, 0);
        wait_wb(20);
        check("i2_wb_cycle", cyc, 13);
        check("i2_mem_rdata", mem_rdata, 32'hDEAD_BEEF);
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        check("i2_wb_one_cycle", wb_en, 0);
        check("halted", halted, 1);
        check("halt_instret", instret, 2);
        check("halt_pc", pc, PC0 + 32'd8);
        seen = 0;
        repeat (4) begin
            step();
            if (bus_req_valid !== 1'b0) seen++;
        end
        check("halt_no_req", seen, 0);
        check("halt_sticky", halted, 1);

        // Reset while a load sits in MEM_WAIT.
        dp_mem_req  = 1'b0;
        ready_delay = 0;
        rst_n = 1'b0;
        repeat (2) step();
        sb_q.delete();
        check("rst2_halted", halted, 0);
        push(32'h0000_0013, 32'h0);
        release_rst();
        wait_exec(10);
        step();
        dp_mem_req = 1'b1;
        wait_exec(10);
        step();
        step();
        check("mw_instret", instret, 1);
        rst_n = 1'b0;
        step();
        sb_q.delete();
        check("mw_rst_pc", pc, PC0);
        check("mw_rst_instret", instret, 0);
        check("mw_rst_mem_rdata", mem_rdata, 0);
        check("mw_rst_valid", bus_req_valid, 0);
        check("mw_rst_exec", exec_valid, 0);
        check("mw_rst_wb", wb_en, 0);
        check("mw_rst_fault", fault, 0);

        // Misaligned pc_next at writeback.
        dp_mem_req = 1'b0;
        pc_fix_en  = 1'b1;
        pc_fix     = 32'h8000_0006;
        push(32'h0000_0013, 32'h0);
        step();
        release_rst();
        wait_wb(10);
        check("mis_wb_cycle", cyc, 4);
        step();
        check("mis_fault", fault, 1);
        check("mis_pc", pc, PC0);
        check("mis_instret", instret, 0);
        check("mis_halted", halted, 0);
        seen = 0;
        repeat (4) begin
            step();
            if (bus_req_valid !== 1'b0) seen++;
        end
        check("mis_no_req", seen, 0);

        // Fetch accepted but never answered.
        rst_n = 1'b0;
        pc_fix_en = 1'b0;
        rsp_on = 1'b0;
        repeat (2) step();
        release_rst();
        check("to_fetch_valid", bus_req_valid, 1);
        while (cyc < 9) step();
        check("to_no_fault_yet", fault, 0);
        step();
        check("to_fault", fault, 1);
        check("to_no_req", bus_req_valid, 0);
        rsp_on = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
